// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } pf_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface fetch_prefetch_unit_if;

  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic        IMemRValid;
  logic [31:0] IMemRData;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemReady,
    input  IMemRValid,
    input  IMemRData
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemReady,
    output IMemRValid,
    output IMemRData
  );

endinterface

// File: rtl/fetch_pf_fifo.sv
// Small synchronous FIFO of {pc, instr} entries; flush empties it in one cycle.
module fetch_pf_fifo
  import fetch_pkg::*;
#(
  parameter  int PF_DEPTH = 2,
  localparam int AW       = $clog2(PF_DEPTH),
  localparam int CW       = $clog2(PF_DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  pf_entry_t     wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output pf_entry_t     head
);

  pf_entry_t      mem [PF_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  always_ff @(posedge CLK) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// IF-stage producer: owns the PC, issues one outstanding imem request, buffers responses.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          PF_DEPTH     = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         StallF,
  input  logic                         RedirectF,
  input  logic [31:0]                  RedirectPC,
  fetch_prefetch_unit_if.master        imem,
  output logic [31:0]                  InstrF,
  output logic [31:0]                  PCPlus4F,
  output logic                         ValidF
);

  localparam int CW = $clog2(PF_DEPTH + 1);
  localparam int OW = CW + 1;

  fetch_state_e  state_q;
  logic [31:0]   pc_q;
  logic [31:0]   tag_q;

  logic [CW-1:0] count;
  pf_entry_t     head;
  pf_entry_t     wentry;

  logic          outst;
  logic          pop;
  logic          push;
  logic          req;
  logic          accept;
  logic [OW-1:0] occ;

  // Credit check counts the in-flight request so a response always has a free slot.
  always_comb begin
    outst  = (state_q != ST_IDLE);
    ValidF = (count != '0);
    pop    = ValidF && !StallF && !RedirectF;
    occ    = {1'b0, count} + OW'(outst) - OW'(pop);
    req    = !RST && !RedirectF
             && ((state_q == ST_IDLE) || imem.IMemRValid)
             && (occ < OW'(PF_DEPTH));
    accept = req && imem.IMemReady;
    push   = (state_q == ST_WAIT) && imem.IMemRValid && !RedirectF;
    wentry = '{pc: tag_q, instr: imem.IMemRData};
  end

  assign imem.IMemReq  = req;
  assign imem.IMemAddr = pc_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VECTOR;
    end else if (RedirectF) begin
      pc_q    <= align_pc(RedirectPC);
      state_q <= (outst && !imem.IMemRValid) ? ST_KILL : ST_IDLE;
    end else begin
      if (accept) pc_q <= pc_q + 32'd4;
      case (state_q)
        ST_IDLE: if (accept) state_q <= ST_WAIT;
        ST_WAIT,
        ST_KILL: if (imem.IMemRValid) state_q <= accept ? ST_WAIT : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Address of the outstanding request, attached to its response on push.
  always_ff @(posedge CLK) begin
    if (accept) tag_q <= pc_q;
  end

  fetch_pf_fifo #(
    .PF_DEPTH (PF_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (RedirectF),
    .count (count),
    .head  (head)
  );

  assign InstrF   = ValidF ? head.instr         : NOP_INSTR;
  assign PCPlus4F = ValidF ? head.pc + 32'd4    : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench: bench-side memory model plus a queue of expected fetch PCs.
module tb_fetch_prefetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        StallF;
  logic        RedirectF;
  logic [31:0] RedirectPC;
  logic [31:0] InstrF;
  logic [31:0] PCPlus4F;
  logic        ValidF;

  fetch_prefetch_unit_if bus ();

  fetch_prefetch_unit #(
    .RESET_VECTOR (RV),
    .PF_DEPTH     (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .StallF     (StallF),
    .RedirectF  (RedirectF),
    .RedirectPC (RedirectPC),
    .imem       (bus),
    .InstrF     (InstrF),
    .PCPlus4F   (PCPlus4F),
    .ValidF     (ValidF)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference state: expected fetch order and the single outstanding memory access.
  logic [31:0] expq[$];
  logic [31:0] model_pc;
  bit          busy;
  bit          dead;
  logic [31:0] maddr;
  int          cnt;
  int          lat;
  int          ready_pct;
  bit          stray;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit stall, input bit redir, input logic [31:0] rpc);
    bit rv;
    bit rdy;
    bit pop_e;
    bit req_e;
    int occ;
    @(negedge CLK);
    rv = 1'b0;
    if (busy) begin
      cnt--;
      if (cnt == 0) rv = 1'b1;
    end
    rdy            = ($urandom_range(99) < ready_pct);
    StallF         = stall;
    RedirectF      = redir;
    RedirectPC     = rpc;
    bus.IMemReady  = rdy;
    bus.IMemRValid = rv || (stray && !busy);
    bus.IMemRData  = rv ? word_of(maddr) : 32'hDEAD_BEEF;
    #1;
    pop_e = (expq.size() > 0) && !stall && !redir;
    occ   = expq.size() + int'(busy) - int'(pop_e);
    req_e = !redir && (!busy || rv) && (occ < DEPTH);
    chk("req", 32'(bus.IMemReq), 32'(req_e));
    if (req_e) chk("addr", bus.IMemAddr, model_pc);
    chk("valid", 32'(ValidF), 32'(expq.size() > 0));
    if (expq.size() > 0) begin
      chk("instr", InstrF, word_of(expq[0]));
      chk("pcplus4", PCPlus4F, expq[0] + 32'd4);
    end else begin
      chk("instr_bubble", InstrF, 32'h0);
      chk("pcplus4_bubble", PCPlus4F, 32'h0);
    end
    if (rv) begin
      busy = 1'b0;
      if (!dead && !redir) expq.push_back(maddr);
    end
    if (pop_e) void'(expq.pop_front());
    if (redir) begin
      expq.delete();
      model_pc = {rpc[31:2], 2'b00};
      if (busy) dead = 1'b1;
    end else if (req_e && rdy) begin
      busy     = 1'b1;
      dead     = 1'b0;
      maddr    = model_pc;
      cnt      = lat;
      model_pc = model_pc + 32'd4;
    end
    @(posedge CLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  // Steps until a request has just been accepted (want_cnt==lat) or is one cycle from responding.
  task automatic wait_mem(input string tag, input int want_cnt);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (busy && cnt == want_cnt) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    RST            = 1'b1;
    StallF         = 1'b0;
    RedirectF      = 1'b0;
    bus.IMemReady  = 1'b0;
    bus.IMemRValid = 1'b0;
    #1;
    chk("rst_valid", 32'(ValidF), 32'd0);
    chk("rst_instr", InstrF, 32'h0);
    chk("rst_pcplus4", PCPlus4F, 32'h0);
    chk("rst_req", 32'(bus.IMemReq), 32'd0);
    expq.delete();
    busy     = 1'b0;
    dead     = 1'b0;
    model_pc = RV;
    @(posedge CLK);
    #1;
    chk("rst_req_hold", 32'(bus.IMemReq), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST            = 1'b1;
    StallF         = 1'b0;
    RedirectF      = 1'b0;
    RedirectPC     = 32'h0;
    bus.IMemReady  = 1'b0;
    bus.IMemRValid = 1'b0;
    bus.IMemRData  = 32'h0;
    model_pc       = RV;
    busy           = 1'b0;
    dead           = 1'b0;
    maddr          = 32'h0;
    cnt            = 0;
    lat            = 1;
    ready_pct      = 100;
    stray          = 1'b0;

    #1;
    chk("init_valid", 32'(ValidF), 32'd0);
    chk("init_instr", InstrF, 32'h0);
    chk("init_pcplus4", PCPlus4F, 32'h0);
    chk("init_req", 32'(bus.IMemReq), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Streaming with a 1-cycle memory.
    run(12);

    // Stall fills the buffer, then release.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
    run(8);

    // Redirect one cycle after accept with a 3-cycle memory.
    lat = 3;
    wait_mem("wait_accept_lat3", 3);
    step(1'b0, 1'b1, 32'h0000_0100);
    run(14);

    // Redirect in the same cycle as the response.
    lat = 2;
    wait_mem("wait_resp_lat2", 1);
    step(1'b0, 1'b1, 32'h0000_0200);
    run(10);

    // Redirect to a misaligned target at the top of the address space.
    lat = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFFE);
    run(8);

    // Memory that never answers, then reset while a request is outstanding.
    lat = 1000000;
    wait_mem("wait_accept_dead", 1000000);
    run(20);
    do_reset();
    lat   = 1;
    stray = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    stray = 1'b0;
    run(10);

    // Randomized traffic: latency, backpressure, stalls and redirects.
    ready_pct = 70;
    for (int i = 0; i < 400; i++) begin
      if (!busy) lat = $urandom_range(1, 4);
      step($urandom_range(99) < 30, $urandom_range(99) < 5, $urandom);
    end
    ready_pct = 100;
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
